// File: rtl/match_ctrl_pkg.sv
// Shared encodings for the match controller: FSM states, winner codes, KO level.
// Pure declarations; no timing or flow control.
package match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RND_RST = 3'd1,
    ST_FIGHT   = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam logic [1:0] HP_KO = 2'd0;

  localparam int unsigned TIMER_W = 5;
  localparam int unsigned PAUSE_W = 4;

  // Distance between two 3-bit positions, never negative.
  function automatic logic [2:0] pos_dist(input logic [2:0] a, input logic [2:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Signal bundle between the match controller and its host/Game side.
// master drives START/HP/POS; slave (the controller) drives status and control.
interface match_ctrl_if;
  logic       START;
  logic [1:0] HP1;
  logic [1:0] HP2;
  logic [2:0] P1_POS;
  logic [2:0] P2_POS;

  logic       GAME_RST;
  logic       ACT_EN;
  logic [2:0] STATE;
  logic [1:0] WINS1;
  logic [1:0] WINS2;
  logic [2:0] ROUND;
  logic [4:0] TIMER;
  logic [2:0] DIST;
  logic [1:0] WINNER;
  logic       MATCH_DONE;

  modport master (
    output START, HP1, HP2, P1_POS, P2_POS,
    input  GAME_RST, ACT_EN, STATE, WINS1, WINS2, ROUND, TIMER, DIST, WINNER, MATCH_DONE
  );

  modport slave (
    input  START, HP1, HP2, P1_POS, P2_POS,
    output GAME_RST, ACT_EN, STATE, WINS1, WINS2, ROUND, TIMER, DIST, WINNER, MATCH_DONE
  );
endinterface

// File: rtl/match_timer.sv
// Loadable down-counter that sticks at zero; load wins over decrement.
// New value visible the cycle after load_i/dec_i; no backpressure.
module match_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/match_ctrl.sv
// Best-of-N fighting match sequencer: rounds, timer, KO/timeout scoring, pause.
// All outputs registered or decoded from state; START only honoured in IDLE/OVER.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 16,
  parameter int unsigned WINS_NEEDED  = 2,
  parameter int unsigned PAUSE_CYCLES = 4,
  parameter int unsigned MAX_ROUNDS   = 5
) (
  input  logic         CLK,
  input  logic         RST,
  match_ctrl_if.slave  bus
);

  localparam logic [TIMER_W-1:0] FIGHT_LOAD = TIMER_W'(ROUND_CYCLES);
  localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [1:0]         WINS_MAX   = 2'(WINS_NEEDED);
  localparam logic [2:0]         ROUNDS_MAX = 3'(MAX_ROUNDS);

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  winner_e    rnd_win;
  logic [1:0] wins1_q, wins1_d;
  logic [1:0] wins2_q, wins2_d;
  logic [2:0] round_q, round_d;
  logic [2:0] dist_q, dist_d;
  logic       first_q;
  logic       ko1, ko2, round_end;

  logic               fight_load, fight_dec;
  logic               pause_load, pause_dec;
  logic [TIMER_W-1:0] fight_cnt;
  logic [PAUSE_W-1:0] pause_cnt;

  match_timer #(.W(TIMER_W)) u_fight_timer (
    .clk        (CLK),
    .rst        (RST),
    .load_i     (fight_load),
    .load_val_i (FIGHT_LOAD),
    .dec_i      (fight_dec),
    .cnt_o      (fight_cnt)
  );

  match_timer #(.W(PAUSE_W)) u_pause_timer (
    .clk        (CLK),
    .rst        (RST),
    .load_i     (pause_load),
    .load_val_i (PAUSE_LOAD),
    .dec_i      (pause_dec),
    .cnt_o      (pause_cnt)
  );

  assign ko1    = (bus.HP1 == HP_KO);
  assign ko2    = (bus.HP2 == HP_KO);
  assign dist_d = pos_dist(bus.P1_POS, bus.P2_POS);

  // HP is not trusted on the first FIGHT cycle: the Game block is just leaving reset.
  assign round_end = (state_q == ST_FIGHT) && !first_q &&
                     (ko1 || ko2 || (fight_cnt == '0));

  always_comb begin
    rnd_win = WIN_DRAW;
    if (ko1 && ko2) begin
      rnd_win = WIN_DRAW;
    end else if (ko1) begin
      rnd_win = WIN_P2;
    end else if (ko2) begin
      rnd_win = WIN_P1;
    end else if (bus.HP1 > bus.HP2) begin
      rnd_win = WIN_P1;
    end else if (bus.HP2 > bus.HP1) begin
      rnd_win = WIN_P2;
    end
  end

  always_comb begin
    state_d    = state_q;
    wins1_d    = wins1_q;
    wins2_d    = wins2_q;
    round_d    = round_q;
    winner_d   = winner_q;
    fight_load = 1'b0;
    fight_dec  = 1'b0;
    pause_load = 1'b0;
    pause_dec  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.START) begin
          state_d  = ST_RND_RST;
          wins1_d  = 2'd0;
          wins2_d  = 2'd0;
          winner_d = WIN_NONE;
          round_d  = 3'd1;
        end
      end

      ST_RND_RST: begin
        fight_load = 1'b1;
        state_d    = ST_FIGHT;
      end

      ST_FIGHT: begin
        fight_dec  = 1'b1;
        pause_load = 1'b1;
        if (round_end) begin
          if ((rnd_win == WIN_P1) && (wins1_q != WINS_MAX)) begin
            wins1_d = wins1_q + 2'd1;
          end
          if ((rnd_win == WIN_P2) && (wins2_q != WINS_MAX)) begin
            wins2_d = wins2_q + 2'd1;
          end

          if (wins1_d == WINS_MAX) begin
            state_d  = ST_OVER;
            winner_d = WIN_P1;
          end else if (wins2_d == WINS_MAX) begin
            state_d  = ST_OVER;
            winner_d = WIN_P2;
          end else if (round_q == ROUNDS_MAX) begin
            state_d  = ST_OVER;
            winner_d = (wins1_d > wins2_d) ? WIN_P1 :
                       (wins2_d > wins1_d) ? WIN_P2 : WIN_DRAW;
          end else begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        pause_dec = 1'b1;
        if (pause_cnt == '0) begin
          state_d = ST_RND_RST;
          round_d = round_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      wins1_q  <= 2'd0;
      wins2_q  <= 2'd0;
      round_q  <= 3'd0;
      winner_q <= WIN_NONE;
      dist_q   <= 3'd0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wins1_q  <= wins1_d;
      wins2_q  <= wins2_d;
      round_q  <= round_d;
      winner_q <= winner_d;
      dist_q   <= dist_d;
      first_q  <= (state_q == ST_RND_RST);
    end
  end

  assign bus.STATE      = state_q;
  assign bus.GAME_RST   = (state_q == ST_IDLE) || (state_q == ST_RND_RST) || (state_q == ST_OVER);
  assign bus.ACT_EN     = (state_q == ST_FIGHT);
  assign bus.MATCH_DONE = (state_q == ST_OVER);
  assign bus.WINS1      = wins1_q;
  assign bus.WINS2      = wins2_q;
  assign bus.ROUND      = round_q;
  assign bus.TIMER      = fight_cnt;
  assign bus.DIST       = dist_q;
  assign bus.WINNER     = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with default parameters (16/2/4/5).
module tb_match_ctrl;
  import match_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   n;

  match_ctrl_if bus ();

  match_ctrl #(
    .ROUND_CYCLES (16),
    .WINS_NEEDED  (2),
    .PAUSE_CYCLES (4),
    .MAX_ROUNDS   (5)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cnt = 1);
    repeat (cnt) @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output int cnt);
    cnt = 0;
    while ((bus.STATE !== s) && (cnt < max)) begin
      step();
      cnt++;
    end
  endtask

  task automatic wait_leave(input logic [2:0] s, input int max, output int cnt);
    cnt = 0;
    while ((bus.STATE === s) && (cnt < max)) begin
      step();
      cnt++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, bus.STATE, 0);
    check({tag, "_wins1"}, bus.WINS1, 0);
    check({tag, "_wins2"}, bus.WINS2, 0);
    check({tag, "_round"}, bus.ROUND, 0);
    check({tag, "_timer"}, bus.TIMER, 0);
    check({tag, "_dist"}, bus.DIST, 0);
    check({tag, "_winner"}, bus.WINNER, 0);
    check({tag, "_done"}, bus.MATCH_DONE, 0);
    check({tag, "_act_en"}, bus.ACT_EN, 0);
    check({tag, "_game_rst"}, bus.GAME_RST, 1);
  endtask

  initial begin
    RST = 1'b1;
    bus.START = 1'b0;
    bus.HP1 = 2'd3;
    bus.HP2 = 2'd3;
    bus.P1_POS = 3'd0;
    bus.P2_POS = 3'd0;
    step(2);
    RST = 1'b0;
    check_reset_vals("rst");

    // Position distance, one cycle of latency, both orderings.
    bus.P1_POS = 3'd1; bus.P2_POS = 3'd6;
    check("dist_before", bus.DIST, 0);
    step();
    check("dist_1_6", bus.DIST, 5);
    bus.P1_POS = 3'd7; bus.P2_POS = 3'd0;
    step();
    check("dist_7_0", bus.DIST, 7);
    bus.P1_POS = 3'd2; bus.P2_POS = 3'd4;
    step();
    check("dist_2_4", bus.DIST, 2);

    // Match 1: P1 wins 2-0 by knockouts.
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check("m1_rndrst", bus.STATE, 1);
    check("m1_rndrst_grst", bus.GAME_RST, 1);
    check("m1_rndrst_round", bus.ROUND, 1);
    step();
    check("m1_fight", bus.STATE, 2);
    check("m1_fight_timer", bus.TIMER, 16);
    check("m1_fight_act", bus.ACT_EN, 1);
    check("m1_fight_grst", bus.GAME_RST, 0);
    check("m1_fight_round", bus.ROUND, 1);
    bus.HP2 = 2'd0;
    step();
    check("m1_first_cycle_ignored", bus.STATE, 2);
    check("m1_timer_dec", bus.TIMER, 15);
    step();
    check("m1_r1_pause", bus.STATE, 3);
    check("m1_r1_wins1", bus.WINS1, 1);
    check("m1_pause_act", bus.ACT_EN, 0);
    check("m1_pause_grst", bus.GAME_RST, 0);
    bus.HP2 = 2'd3;
    step(3);
    check("m1_pause_len", bus.STATE, 3);
    step();
    check("m1_r2_rndrst", bus.STATE, 1);
    check("m1_r2_round", bus.ROUND, 2);
    step(2);
    bus.HP2 = 2'd0;
    step();
    check("m1_over", bus.STATE, 4);
    check("m1_winner", bus.WINNER, 1);
    check("m1_done", bus.MATCH_DONE, 1);
    check("m1_wins1", bus.WINS1, 2);
    check("m1_over_grst", bus.GAME_RST, 1);
    bus.HP2 = 2'd3;
    step(2);
    check("m1_over_held", bus.STATE, 4);
    check("m1_winner_held", bus.WINNER, 1);

    // Match 2: draw by double KO, then KO at timeout, then timeout win for P2.
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check("m2_restart", bus.STATE, 1);
    check("m2_wins_clr", bus.WINS1, 0);
    check("m2_winner_clr", bus.WINNER, 0);
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check("m2_start_ignored", bus.STATE, 2);
    bus.HP1 = 2'd0; bus.HP2 = 2'd0;
    step();
    check("m2_dko_pause", bus.STATE, 3);
    check("m2_dko_wins1", bus.WINS1, 0);
    check("m2_dko_wins2", bus.WINS2, 0);
    bus.HP1 = 2'd3; bus.HP2 = 2'd3;
    wait_state(3'd2, 10, n);
    check("m2_r2_fight", bus.STATE, 2);
    check("m2_r2_round", bus.ROUND, 2);
    n = 0;
    while ((bus.TIMER !== 5'd0) && (n < 20)) begin
      step();
      n++;
    end
    check("m2_r2_count", n, 16);
    check("m2_r2_still_fight", bus.STATE, 2);
    bus.HP1 = 2'd0;
    step();
    check("m2_ko_timeout_wins2", bus.WINS2, 1);
    check("m2_ko_timeout_wins1", bus.WINS1, 0);
    bus.HP1 = 2'd1; bus.HP2 = 2'd2;
    wait_state(3'd2, 10, n);
    wait_leave(3'd2, 40, n);
    check("m2_r3_len", n, 17);
    check("m2_over", bus.STATE, 4);
    check("m2_winner", bus.WINNER, 2);
    check("m2_wins2", bus.WINS2, 2);
    check("m2_round", bus.ROUND, 3);

    // Match 3: five timeout draws exhaust the round limit.
    bus.HP1 = 2'd3; bus.HP2 = 2'd3;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      wait_state(3'd2, 10, n);
      check("m3_fight", bus.STATE, 2);
      check("m3_round", bus.ROUND, r);
      wait_leave(3'd2, 40, n);
      check("m3_len", n, 17);
      check("m3_wins1", bus.WINS1, 0);
      check("m3_wins2", bus.WINS2, 0);
    end
    check("m3_over", bus.STATE, 4);
    check("m3_winner", bus.WINNER, 3);
    check("m3_done", bus.MATCH_DONE, 1);

    // Reset mid-FIGHT beats START and a simultaneous KO.
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step(3);
    check("m4_fight", bus.STATE, 2);
    RST = 1'b1; bus.START = 1'b1; bus.HP2 = 2'd0;
    bus.P1_POS = 3'd5; bus.P2_POS = 3'd1;
    step();
    RST = 1'b0; bus.START = 1'b0; bus.HP2 = 2'd3;
    bus.P1_POS = 3'd0; bus.P2_POS = 3'd0;
    check_reset_vals("midrst");
    step();
    check("midrst_stay_idle", bus.STATE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter ROUND_CYCLES, default 16, FIGHT-phase length in clock cycles (2..31).
REQ-002 Parameter WINS_NEEDED, default 2, round wins that end the match (1..3).
REQ-003 Parameter PAUSE_CYCLES, default 4, idle cycles between rounds (1..15).
REQ-004 Parameter MAX_ROUNDS, default 5, round limit per match (1..7).
REQ-005 CLK  input  1  single system clock; all state changes on the rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 START  input  1  level; begins a match when sampled high in IDLE or OVER.
REQ-008 HP1, HP2  input  2 each  player hit points from the Game block; 0 = knocked out.
REQ-009 P1_POS, P2_POS  input  3 each  player positions from the Game block.
REQ-010 GAME_RST  output  1  active-high reset to the Game block.
REQ-011 ACT_EN  output  1  high only in FIGHT; upstream gates P1/P2 action codes to 6'b000000 when low.
REQ-012 STATE  output  3  IDLE=0, RND_RST=1, FIGHT=2, PAUSE=3, OVER=4.
REQ-013 WINS1, WINS2  output  2 each  round wins per player.
REQ-014 ROUND  output  3  current round number, 1-based; 0 in IDLE.
REQ-015 TIMER  output  5  remaining FIGHT cycles.
REQ-016 DIST  output  3  registered |P1_POS - P2_POS|.
REQ-017 WINNER  output  2  00 none, 01 P1, 10 P2, 11 draw.
REQ-018 MATCH_DONE  output  1  high in OVER.

Function
REQ-019 IDLE: GAME_RST=1, ACT_EN=0; START=1 -> RND_RST, clear WINS1/WINS2/WINNER, set ROUND=1.
REQ-020 RND_RST: exactly one cycle; GAME_RST=1, TIMER loaded with ROUND_CYCLES; -> FIGHT.
REQ-021 FIGHT: GAME_RST=0, ACT_EN=1, TIMER decrements by 1 per cycle, saturating at 0.
REQ-022 FIGHT ignores HP on its first cycle, because the Game block's outputs are not yet valid after reset.
REQ-023 From the second FIGHT cycle on, the round ends in the cycle that HP1==0, HP2==0, or TIMER==0 is sampled.
REQ-024 Round outcome priority:
  - KO is evaluated before timeout.
  - HP1==0 and HP2==0 in the same cycle is a draw.
  - A single KO awards the round to the other player.
  - At timeout, the higher HP wins the round; equal HP is a draw.
REQ-025 A draw awards no win; a winning player's WINS increments by 1, saturating at WINS_NEEDED.
REQ-026 After a round:
  - If either WINS reaches WINS_NEEDED -> OVER, WINNER = that player.
  - Otherwise, if ROUND==MAX_ROUNDS -> OVER, WINNER = player with more wins, or 11 if wins are equal.
  - Otherwise -> PAUSE.
REQ-027 PAUSE: ACT_EN=0, GAME_RST=0, Game state held; after PAUSE_CYCLES cycles -> RND_RST with ROUND+1.
REQ-028 OVER: GAME_RST=1, MATCH_DONE=1, WINS/ROUND/WINNER held; START=1 behaves as in IDLE and goes directly to RND_RST.
REQ-029 START is ignored in RND_RST, FIGHT and PAUSE.
REQ-030 DIST updates every cycle in all states, one cycle after the positions are sampled.
REQ-031 All outputs are registered or decoded from STATE only; no combinational path from HP/POS inputs to outputs.

Reset
REQ-032 RST=1 at a clock edge forces, on that edge and regardless of state:
  - STATE=IDLE.
  - WINS1=WINS2=0, ROUND=0, TIMER=0, DIST=0, WINNER=00.
  - MATCH_DONE=0, ACT_EN=0, GAME_RST=1.
REQ-033 RST takes priority over START and over any round-end event in the same cycle.

Structure
REQ-034 Shared package holds: the STATE encodings, the WINNER encodings (NONE/P1/P2/DRAW), and the HP KO constant 2'd0.
REQ-035 One sub-module, match_timer: a loadable down-counter with saturation at 0, used for both the FIGHT and PAUSE counts.

Verification
REQ-036 Reset, then START=1 -> 1 cycle RND_RST (GAME_RST=1), then FIGHT with TIMER=16, ACT_EN=1, ROUND=1.
REQ-037 In round 1, HP2 driven to 0 -> WINS1=1, PAUSE for 4 cycles, RND_RST, ROUND=2; a second HP2=0 -> OVER, WINNER=01, MATCH_DONE=1.
REQ-038 HP1=HP2=0 in the same cycle -> draw, no win awarded; KO and TIMER=0 together -> KO result applies.
REQ-039 No KO, TIMER reaches 0 with HP1=1, HP2=2 -> WINS2 increments; with HP1=HP2 -> draw; 5 consecutive draws -> OVER, WINNER=11.
REQ-040 P1_POS=1, P2_POS=6 -> DIST=5 one cycle later; RST asserted mid-FIGHT -> IDLE with all REQ-032 values on the next edge.
